gf4_normal_mult: RTL and testbench
==================================

// Module: gf4_normal_mult
// PURPOSE
//  - GF(2^2) multiplier in normal basis {W, W^2}, where W^2+W+1=0.
//  - Leaf block of the tower-field (GF(2^8) -> GF(2^4) -> GF(2^2)) AES S-box datapath.
//  - Registered output with a valid tag, one cycle latency.
//  - LANES independent multipliers are packed side by side so wider stages can share one instance.
// PARAMETERS
//  - LANES  1  number of independent 2-bit multiplies per cycle (>=1)
// PORTS
//  - clk        in   1         rising-edge clock, the block's only clock
//  - rst_n      in   1         asynchronous, active-low reset
//  - in_valid   in   1         x/y carry valid operands this cycle
//  - x          in   2*LANES   operand A; lane i = x[2i+1:2i]
//  - y          in   2*LANES   operand B; lane i = y[2i+1:2i]
//  - out_valid  out  1         result holds the product of operands sampled one cycle earlier
//  - result     out  2*LANES   product; lane i = result[2i+1:2i]
// BEHAVIOUR
//  - Encoding per lane: bit1 = coefficient of W, bit0 = coefficient of W^2.
//    - 2'b11 = W + W^2 = 1 (multiplicative identity); 2'b00 = 0.
//  - Lane product, all operations XOR/AND:
//    - e     = (x1^x0) & (y1^y0)
//    - q1    = (x1&y1) ^ e
//    - q0    = (x0&y0) ^ e
//    - result = {q1, q0}
//  - Full value table, per lane:
//    - anything*00 = 00
//    - 11 is the identity
//    - 10*10 = 01, 01*01 = 10, 10*01 = 11
//    - the operation is commutative
//  - Timing:
//    - Combinational product is registered on every rising clk edge where in_valid=1.
//    - result and out_valid are valid after exactly 1 cycle.
//    - No backpressure; a new operand pair is accepted every cycle.
//  - Hold:
//    - in_valid=0 -> result holds its last value.
//    - out_valid is loaded from in_valid every cycle, so it drops to 0 one cycle after in_valid drops.
//  - Reset:
//    - rst_n low asynchronously forces result=0 and out_valid=0 immediately, independent of clk.
//    - Reset asserted mid-stream discards the in-flight product.
//    - First accepted operand pair after rst_n rises yields out_valid=1 one cycle later.
//  - Lanes are fully independent: no carries or interaction between lanes.
//  - No X propagation on out_valid after reset; x/y values are don't-care while in_valid=0.
// TESTING
//  - Reset: rst_n=0 mid-operation, clk stopped -> result=00, out_valid=0 immediately.
//  - LANES=1 directed vectors, one per cycle, in_valid=1, each checked 1 cycle later:
//    - 01*10 -> 11
//    - 10*11 -> 10
//    - 11*01 -> 01
//    - 11*11 -> 11
//    - 01*01 -> 10
//    - 10*10 -> 01
//  - Exhaustive: all 16 x/y pairs vs table; swap operands -> identical result; x=00 -> 00.
//  - Hold: in_valid 1 then 0 with x/y changing -> result holds, out_valid 1 then 0.
//  - LANES=4, x=8'b01_10_11_00, y=8'b01_10_01_11 -> result=8'b10_01_01_00 after 1 cycle.
//  - Back-to-back: 8 random pairs on consecutive cycles -> out_valid stays 1, results match model in order.

Source files
------------

// File: rtl/gf4_normal_mult.sv
// gf4_normal_mult: GF(2^2) multiplier in the normal basis {W, W^2}, W^2 + W + 1 = 0.
// Leaf block of the tower-field AES S-box datapath. LANES independent 2-bit multiplies are
// packed side by side; the product is registered with a valid tag (one cycle latency).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears result_o and out_valid_o
//   in_valid_i   x_i/y_i carry valid operands this cycle
//   x_i, y_i     operands, lane i at [2i+1:2i]; bit1 = coeff of W, bit0 = coeff of W^2
//   out_valid_o  result_o holds the product of operands sampled one cycle earlier
//   result_o     product, lane i at [2i+1:2i]
module gf4_normal_mult #(
  parameter int unsigned LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  input  logic [2*LANES-1:0]   x_i,
  input  logic [2*LANES-1:0]   y_i,
  output logic                 out_valid_o,
  output logic [2*LANES-1:0]   result_o
);

  // Normal-basis product. The shared term e = (x1^x0)&(y1^y0) folds the W^3 = 1 = W + W^2
  // contributions of the cross products back into both coordinates.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  logic [2*LANES-1:0] prod;
  logic [2*LANES-1:0] result_d, result_q;
  logic               valid_d, valid_q;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[2*i +: 2] = gf4_mul(x_i[2*i +: 2], y_i[2*i +: 2]);
    end
  end

  // Result only loads on valid operands; the valid tag follows in_valid_i every cycle.
  always_comb begin
    result_d = in_valid_i ? prod : result_q;
    valid_d  = in_valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o    = result_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_gf4_normal_mult.sv
// Self-checking bench for gf4_normal_mult: one LANES=1 and one LANES=4 instance share the clock,
// reset and in_valid. Expected products come from a log/antilog model over powers of W.
module tb_gf4_normal_mult;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] x1, y1, r1;
  logic       ov1;
  logic [7:0] x4, y4, r4;
  logic       ov4;

  int checks = 0;
  int failures = 0;

  always #5 if (clk_run) clk = ~clk;

  gf4_normal_mult #(.LANES(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .x_i         (x1),
    .y_i         (y1),
    .out_valid_o (ov1),
    .result_o    (r1)
  );

  gf4_normal_mult #(.LANES(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .x_i         (x4),
    .y_i         (y4),
    .out_valid_o (ov4),
    .result_o    (r4)
  );

  // Nonzero elements are W^k: 11 = W^0 = 1, 10 = W^1, 01 = W^2.
  function automatic int log_w(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b10:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] exp_w(input int k);
    case (k % 3)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return exp_w(log_w(a) + log_w(b));
  endfunction

  function automatic logic [7:0] ref_mul4(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = ref_mul(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] dx [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10};
  logic [1:0] dy [6] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
  logic [1:0] de [6] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};

  initial begin
    logic [7:0] exp4;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x1 = '0; y1 = '0; x4 = '0; y4 = '0;
    #2;
    check("reset_r1", {6'b0, r1}, 8'h00);
    check("reset_ov1", {7'b0, ov1}, 8'h00);
    check("reset_r4", r4, 8'h00);
    check("reset_ov4", {7'b0, ov4}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    cycle();
    check("idle_ov1", {7'b0, ov1}, 8'h00);

    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x1 = dx[i];
      y1 = dy[i];
      cycle();
      check($sformatf("dir%0d_r", i), {6'b0, r1}, {6'b0, de[i]});
      check($sformatf("dir%0d_ov", i), {7'b0, ov1}, 8'h01);
    end

    x4 = 8'b01_10_11_00;
    y4 = 8'b01_10_01_11;
    cycle();
    check("lanes4_vec", r4, 8'b10_01_01_00);
    check("lanes4_ov", {7'b0, ov4}, 8'h01);
    exp4 = 8'b10_01_01_00;

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        x1 = 2'(a);
        y1 = 2'(b);
        cycle();
        check($sformatf("exh_%0d_%0d", a, b), {6'b0, r1}, {6'b0, ref_mul(2'(a), 2'(b))});
        x1 = 2'(b);
        y1 = 2'(a);
        cycle();
        check($sformatf("swap_%0d_%0d", a, b), {6'b0, r1}, {6'b0, ref_mul(2'(a), 2'(b))});
      end
    end

    x1 = 2'b10;
    y1 = 2'b10;
    cycle();
    check("hold_load", {6'b0, r1}, 8'h01);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x1 = 2'($urandom);
      y1 = 2'($urandom);
      x4 = 8'($urandom);
      y4 = 8'($urandom);
      cycle();
      check($sformatf("hold%0d_r1", i), {6'b0, r1}, 8'h01);
      check($sformatf("hold%0d_ov1", i), {7'b0, ov1}, 8'h00);
      check($sformatf("hold%0d_r4", i), r4, exp4);
    end

    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] a1, b1;
      logic [7:0] a4, b4;
      a1 = 2'($urandom); b1 = 2'($urandom);
      a4 = 8'($urandom); b4 = 8'($urandom);
      x1 = a1; y1 = b1; x4 = a4; y4 = b4;
      cycle();
      check($sformatf("b2b%0d_r1", i), {6'b0, r1}, {6'b0, ref_mul(a1, b1)});
      check($sformatf("b2b%0d_ov1", i), {7'b0, ov1}, 8'h01);
      check($sformatf("b2b%0d_r4", i), r4, ref_mul4(a4, b4));
      check($sformatf("b2b%0d_ov4", i), {7'b0, ov4}, 8'h01);
    end

    // Mid-stream reset with the clock stopped.
    x1 = 2'b11; y1 = 2'b10; x4 = 8'hff; y4 = 8'haa;
    cycle();
    check("pre_rst_r1", {6'b0, r1}, 8'h02);
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_r1", {6'b0, r1}, 8'h00);
    check("async_rst_ov1", {7'b0, ov1}, 8'h00);
    check("async_rst_r4", r4, 8'h00);
    check("async_rst_ov4", {7'b0, ov4}, 8'h00);
    #10;
    rst_n = 1'b1;
    x1 = 2'b01; y1 = 2'b10;
    #1;
    clk_run = 1'b1;
    cycle();
    check("post_rst_r1", {6'b0, r1}, 8'h03);
    check("post_rst_ov1", {7'b0, ov1}, 8'h01);
    in_valid = 1'b0;
    cycle();
    check("drop_ov1", {7'b0, ov1}, 8'h00);
    check("drop_r1", {6'b0, r1}, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
